// File: rtl/ascon_soc_dec_driver_if.sv
// Host-side byte-stream bundle for ascon_soc_dec_driver: input and result streams with valid/ready handshakes.
interface ascon_soc_dec_driver_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ascon_soc_dec_driver.sv
// Sequences one Ascon decryption: collects key/nonce/AD/CT bytes, loads the core, starts it, and streams the result out.
// Optional START watchdog compiled in with `define ASCON_DRV_TIMEOUT_EN.
module ascon_soc_dec_driver #(
  parameter int K       = 128,
  parameter int L       = 16,
  parameter int Y       = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  ascon_soc_dec_driver_if.slave  host,
  output logic                   core_rst_n,
  output logic                   core_in_sel,
  output logic [31:0]            core_in_word,
  output logic                   core_start_sel,
  output logic                   core_start,
  input  logic                   core_ready,
  output logic                   core_out_sel,
  input  logic [7:0]             core_byte,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned KB  = K / 8;
  localparam int unsigned LB  = L / 8;
  localparam int unsigned YB  = Y / 8;
  localparam int unsigned T   = KB + 16 + LB + YB;
  localparam int unsigned R   = YB + 16;
  localparam int unsigned BCW = $clog2(T + 1);
  localparam int unsigned IW  = $clog2(T);
  localparam int unsigned RCW = $clog2(R + 1);

  localparam logic [BCW-1:0] T_LAST = BCW'(T - 1);
  localparam logic [RCW-1:0] R_ALL  = RCW'(R);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CRST,
    S_LOAD,
    S_START,
    S_READ,
    S_WRAP
`ifdef ASCON_DRV_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [4:0]     word_cnt_q, word_cnt_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           cap_pend_q, cap_pend_d;
  logic [7:0]     buf_q [T];

  logic           in_ready_i;
  logic           rst_n_i;
  logic           in_sel_i;
  logic           start_i;
  logic           out_sel_i;
  logic [31:0]    lane_word;
  logic           accept;

`ifdef ASCON_DRV_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_i;
`endif

  assign accept = (state_q == S_COLLECT) && host.in_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_COLLECT;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cap_pend_q  <= 1'b0;
      for (int unsigned i = 0; i < T; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cap_pend_q  <= cap_pend_d;
      if (accept) buf_q[IW'(byte_cnt_q)] <= host.in_data;
    end
  end

`ifdef ASCON_DRV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

  // Lane w packs byte w of each field; short fields pad with zero past their length.
  always_comb begin
    int unsigned w;
    w         = 32'(word_cnt_q);
    lane_word = '0;
    if (state_q == S_LOAD) begin
      if (w < KB) lane_word[7:0]   = buf_q[IW'(w)];
      lane_word[15:8]              = buf_q[IW'(KB + w)];
      if (w < LB) lane_word[23:16] = buf_q[IW'(KB + 16 + w)];
      if (w < YB) lane_word[31:24] = buf_q[IW'(KB + 16 + LB + w)];
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cap_pend_d  = 1'b0;
    in_ready_i  = 1'b0;
    rst_n_i     = 1'b1;
    in_sel_i    = 1'b0;
    start_i     = 1'b0;
    out_sel_i   = 1'b0;
`ifdef ASCON_DRV_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_i       = 1'b0;
`endif

    case (state_q)
      S_COLLECT: begin
        in_ready_i = 1'b1;
        if (host.in_valid) begin
          if (byte_cnt_q == T_LAST) begin
            byte_cnt_d = '0;
            state_d    = S_CRST;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end

      S_CRST: begin
        rst_n_i = 1'b0;
        if (word_cnt_q == 5'd1) begin
          word_cnt_d = '0;
          state_d    = S_LOAD;
        end else begin
          word_cnt_d = word_cnt_q + 5'd1;
        end
      end

      S_LOAD: begin
        in_sel_i = 1'b1;
        if (word_cnt_q == 5'd15) begin
          word_cnt_d = '0;
          state_d    = S_START;
        end else begin
          word_cnt_d = word_cnt_q + 5'd1;
        end
      end

      S_START: begin
        start_i = 1'b1;
        if (core_ready) begin
          state_d = S_READ;
`ifdef ASCON_DRV_TIMEOUT_EN
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_ERR;
        end else begin
          tmo_d   = tmo_q + TW'(1);
`endif
        end
      end

      // One readout strobe per result byte, issued only once the previous byte has left.
      S_READ: begin
        if (cap_pend_q) begin
          out_data_d  = core_byte;
          out_valid_d = 1'b1;
        end else if (out_valid_q) begin
          if (host.out_ready) begin
            out_valid_d = 1'b0;
            if (rd_cnt_q == R_ALL) begin
              rd_cnt_d = '0;
              state_d  = S_WRAP;
            end
          end
        end else if (rd_cnt_q != R_ALL) begin
          out_sel_i  = 1'b1;
          cap_pend_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + RCW'(1);
        end
      end

      S_WRAP: begin
        out_sel_i = 1'b1;
        state_d   = S_COLLECT;
      end

`ifdef ASCON_DRV_TIMEOUT_EN
      S_ERR: begin
        err_i   = 1'b1;
        rst_n_i = 1'b0;
      end
`endif

      default: state_d = S_COLLECT;
    endcase
  end

  // Outputs are forced to their reset values for as long as rst is held low.
  assign host.in_ready  = rst & in_ready_i;
  assign host.out_valid = rst & out_valid_q;
  assign host.out_data  = rst ? out_data_q : '0;
  assign core_rst_n     = rst & rst_n_i;
  assign core_in_sel    = rst & in_sel_i;
  assign core_in_word   = rst ? lane_word : '0;
  assign core_start_sel = rst & start_i;
  assign core_start     = rst & start_i;
  assign core_out_sel   = rst & out_sel_i;
  assign busy           = rst & (state_q != S_COLLECT);
`ifdef ASCON_DRV_TIMEOUT_EN
  assign err            = rst & err_i;
`else
  assign err            = 1'b0;
`endif

endmodule

// File: doc/ascon_soc_dec_driver.md
ASCON_SOC_DEC_DRIVER -- requirements
Module: ascon_soc_dec_driver

Interface
REQ-001 SHALL have parameter K, default 128, key bits; multiple of 8, at most 128.
REQ-002 SHALL have parameter L, default 16, associated-data bits; multiple of 8, 8..128.
REQ-003 SHALL have parameter Y, default 16, ciphertext bits; multiple of 8, 8..128.
REQ-004 SHALL have parameter TIMEOUT, default 4096, START-state watchdog limit in cycles.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 in_data  in  8  host byte stream; in_valid in 1; in_ready out 1; transfer when both high.
REQ-008 out_data  out  8  result byte; out_valid out 1; out_ready in 1; transfer when both high.
REQ-009 core_rst_n  out  1  active-low reset to decryption core wrapper.
REQ-010 core_in_sel  out  1  input-word strobe; core_in_word  out  32  packed lane word.
REQ-011 core_start_sel, core_start  out  1 each  start strobe pair; core_ready  in  1  decryption done.
REQ-012 core_out_sel  out  1  readout strobe; core_byte  in  8  registered result byte from core.
REQ-013 busy  out  1  high outside COLLECT; err  out  1  watchdog error flag.

Function
REQ-014 Input order SHALL be K/8 key bytes, 16 nonce bytes, L/8 AD bytes, Y/8 CT bytes, each field MSB-first; T = K/8+16+L/8+Y/8 bytes per operation.
REQ-015 States SHALL be COLLECT, CRST, LOAD, START, READ, WRAP (and ERR per REQ-029); reset enters COLLECT.
REQ-016 COLLECT: in_ready=1, bytes stored in field registers; on T-th accepted byte go to CRST next cycle.
REQ-017 CRST: core_rst_n=0 for exactly 2 cycles, then LOAD; core_rst_n=1 in all other states except during rst.
REQ-018 LOAD: core_in_sel=1 for exactly 16 consecutive cycles, w=0..15; core_in_word = {ct byte w, ad byte w, nonce byte w, key byte w} (bits 31:24 down to 7:0), byte w counted from MSB; lane byte w SHALL be 0x00 when w >= field length in bytes.
REQ-019 START: core_start_sel=core_start=1 held until sampled core_ready=1, then both deasserted and go to READ.
REQ-020 READ: R = Y/8+16 result bytes (plaintext then tag); core_out_sel pulsed one cycle only when out_valid=0 and no capture pending; core_byte captured into out_data the following cycle with out_valid=1.
REQ-021 out_data/out_valid SHALL hold stable until out_ready; out_valid clears the cycle after handshake.
REQ-022 After R-th byte handshake go to WRAP: one extra core_out_sel pulse (core readout-pointer wrap), result not captured, then COLLECT.
REQ-023 in_ready SHALL be 0 in every state except COLLECT; bytes offered elsewhere are not consumed.
REQ-024 core_in_sel, core_start_sel and core_out_sel SHALL be mutually exclusive in every cycle.
REQ-025 Byte counter and word counter SHALL be sized to hold T and 16 without wrap; counters clear on state entry.

Reset
REQ-026 While rst=0: state COLLECT, all counters and field registers 0, in_ready=0, out_valid=0, out_data=0x00, all core strobes 0, core_in_word=0, core_rst_n=0, busy=0, err=0.
REQ-027 rst asserted mid-operation SHALL abort immediately; partially collected bytes discarded; first cycle after release in_ready=1.

Configuration
REQ-028 Macro ASCON_DRV_TIMEOUT_EN SHALL compile in the START watchdog.
REQ-029 With it: cycle counter starts at START entry; if core_ready not seen within TIMEOUT cycles, go to ERR: err=1, start strobes 0, core_rst_n=0, in_ready=0; ERR left only by rst.
REQ-030 Without it: no counter, START waits indefinitely, err tied 0, ERR state absent.

Verification
REQ-031 Defaults, key 00..0F, nonce 10..1F, AD A0A1, CT C0C1 (36 bytes) -> 2-cycle core_rst_n low, then core_in_word 0xC0A01000, 0xC1A11101, 0x00001202 ... 0x00001F0F over 16 cycles.
REQ-032 Core model raises core_ready 10 cycles after start, returns bytes 0x50..0x61 -> 18 out bytes 0x50..0x61 in order, 19 core_out_sel pulses total, then in_ready=1.
REQ-033 out_ready low 20 cycles on byte 3 -> out_data held, no core_out_sel during stall, no byte lost or duplicated.
REQ-034 rst pulsed at LOAD word 7 -> all outputs at reset values, core_in_sel 0, fresh 36-byte operation completes correctly.
REQ-035 ASCON_DRV_TIMEOUT_EN, core_ready held 0 -> err=1 exactly 4096 cycles after START entry, in_ready stays 0 until rst.
REQ-036 in_valid=1 continuously during READ -> in_ready=0, no bytes consumed until COLLECT.
